// File: rtl/not16_chk_pkg.sv
// Shared types and constants for the NOT16 response checker.
package not16_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned     CNT_W         = 16;
  localparam logic [CNT_W-1:0] ERR_SAT      = 16'hFFFF;
  localparam int unsigned     DEFAULT_WIDTH = 16;

endpackage

// File: rtl/resp_delay.sv
// Valid+data delay line aligning an applied vector with its returned response.
// DEPTH=0 is a combinational pass-through.
module resp_delay #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid_c,
  output logic [WIDTH-1:0] out_data_c
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok   = &{1'b0, clk, rst, clr};
    assign out_valid_c = in_valid;
    assign out_data_c  = in_data;
  end else begin : g_dly
    localparam int unsigned DW = DEPTH * WIDTH;
    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat;

    // Newest entry enters at the bottom; the oldest is the top slice.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= '0;
        dat <= '0;
      end else begin
        vld <= clr ? '0 : ((vld << 1) | DEPTH'(in_valid));
        dat <= (dat << WIDTH) | DW'(in_data);
      end
    end

    assign out_valid_c = vld[DEPTH-1];
    assign out_data_c  = dat[DW-1 -: WIDTH];
  end

endmodule

// File: rtl/not16_resp_checker.sv
// Compares NOT16 responses against ~x, counts vectors/mismatches, reports pass/fail.
// Optional diff_mask output under `NOT16_CHK_DIFF_MASK_EN.
module not16_resp_checker
  import not16_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned NUM_VECTORS = 100,
  parameter int unsigned LATENCY     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_fail_x,
  output logic [WIDTH-1:0] first_fail_out
`ifdef NOT16_CHK_DIFF_MASK_EN
  ,
  output logic [WIDTH-1:0] diff_mask
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);

  state_t           state, state_n;
  logic             clr_c, acc_c, dv_c, cmp_c, miss_c;
  logic [WIDTH-1:0] dx_c, exp_c;
  logic [CNT_W-1:0] vec_n, err_n;
  logic [WIDTH-1:0] ffx_n, ffo_n;
  logic             busy_n, done_n, pass_n;
`ifdef NOT16_CHK_DIFF_MASK_EN
  logic [WIDTH-1:0] mask_n;
`endif

  assign clr_c = start && (state != RUN);
  assign acc_c = vec_valid && (state == RUN);

  resp_delay #(
    .DEPTH(LATENCY),
    .WIDTH(WIDTH)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_c),
    .in_valid   (acc_c),
    .in_data    (x),
    .out_valid_c(dv_c),
    .out_data_c (dx_c)
  );

  // Late in-flight vectors emerge after DONE and are ignored here.
  assign cmp_c  = dv_c && (state == RUN);
  assign exp_c  = ~dx_c;
  assign miss_c = (out != exp_c);

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    vec_n   = vec_count;
    err_n   = err_count;
    ffx_n   = first_fail_x;
    ffo_n   = first_fail_out;
`ifdef NOT16_CHK_DIFF_MASK_EN
    mask_n  = diff_mask;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          vec_n   = '0;
          err_n   = '0;
          ffx_n   = '0;
          ffo_n   = '0;
`ifdef NOT16_CHK_DIFF_MASK_EN
          mask_n  = '0;
`endif
        end
      end
      RUN: begin
        if (cmp_c) begin
          vec_n = vec_count + CNT_W'(1);
`ifdef NOT16_CHK_DIFF_MASK_EN
          mask_n = diff_mask | (out ^ exp_c);
`endif
          if (miss_c) begin
            if (err_count == '0) begin
              ffx_n = dx_c;
              ffo_n = out;
            end
            if (err_count != ERR_SAT) err_n = err_count + CNT_W'(1);
          end
          if (vec_n == LAST_CNT) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_x   <= '0;
      first_fail_out <= '0;
`ifdef NOT16_CHK_DIFF_MASK_EN
      diff_mask      <= '0;
`endif
    end else begin
      state          <= state_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      vec_count      <= vec_n;
      err_count      <= err_n;
      first_fail_x   <= ffx_n;
      first_fail_out <= ffo_n;
`ifdef NOT16_CHK_DIFF_MASK_EN
      diff_mask      <= mask_n;
`endif
    end
  end

endmodule

// File: tb/tb_not16_resp_checker.sv
// Scoreboard bench: three checker instances (LAT0/100, LAT3/10, LAT0/65535) run in parallel.
`timescale 1ns/1ps
module tb_not16_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] vec;
    logic [15:0] err;
    logic [15:0] ffx;
    logic [15:0] ffo;
    logic        pass;
    logic [15:0] mask;
    int unsigned done_cyc;
  } exp_t;

  exp_t q0[$], q3[$], qs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a run's outcome is determined by the list of counted (x, out) pairs.
  function automatic exp_t model(input logic [15:0] xs[$], input logic [15:0] os[$],
                                 input int unsigned dcyc);
    exp_t e;
    int   nerr;
    logic [15:0] d;
    e = '{default: 0};
    nerr = 0;
    for (int i = 0; i < xs.size(); i++) begin
      d = os[i] ^ ~xs[i];
      e.mask = e.mask | d;
      if (d != 16'h0) begin
        if (nerr == 0) begin
          e.ffx = xs[i];
          e.ffo = os[i];
        end
        nerr++;
      end
    end
    e.vec      = 16'(xs.size());
    e.err      = (nerr > 65535) ? 16'hFFFF : 16'(nerr);
    e.pass     = (nerr == 0);
    e.done_cyc = dcyc;
    return e;
  endfunction

  task automatic cmp_run(input string t, input exp_t e, input logic [15:0] vc, input logic [15:0] ec,
                         input logic [15:0] fx, input logic [15:0] fo, input logic b, input logic p);
    chk({t, " vec_count"}, 32'(vc), 32'(e.vec));
    chk({t, " err_count"}, 32'(ec), 32'(e.err));
    chk({t, " first_fail_x"}, 32'(fx), 32'(e.ffx));
    chk({t, " first_fail_out"}, 32'(fo), 32'(e.ffo));
    chk({t, " pass"}, 32'(p), 32'(e.pass));
    chk({t, " busy at done"}, 32'(b), 32'd0);
    chk({t, " done cycle"}, cyc, e.done_cyc);
  endtask

  // ---------------- instance u0: LATENCY=0, NUM_VECTORS=100
  logic rst0, start0, vv0, busy0, done0, pass0;
  logic [15:0] x0, o0, vc0, ec0, fx0, fo0;
`ifdef NOT16_CHK_DIFF_MASK_EN
  logic [15:0] dm0;
`endif
  not16_resp_checker #(.WIDTH(16), .NUM_VECTORS(100), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .vec_valid(vv0), .x(x0), .out(o0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vc0), .err_count(ec0),
    .first_fail_x(fx0), .first_fail_out(fo0)
`ifdef NOT16_CHK_DIFF_MASK_EN
    , .diff_mask(dm0)
`endif
  );

  // ---------------- instance u3: LATENCY=3, NUM_VECTORS=10
  logic rst3, start3, vv3, busy3, done3, pass3;
  logic [15:0] x3, w3, o3, vc3, ec3, fx3, fo3;
  logic [15:0] wp3 [3];
`ifdef NOT16_CHK_DIFF_MASK_EN
  logic [15:0] dm3;
`endif
  // Bench stand-in for a NOT16 whose response appears 3 cycles after x.
  always @(posedge clk) begin
    wp3[0] <= w3;
    wp3[1] <= wp3[0];
    wp3[2] <= wp3[1];
  end
  assign o3 = wp3[2];
  not16_resp_checker #(.WIDTH(16), .NUM_VECTORS(10), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3), .vec_valid(vv3), .x(x3), .out(o3),
    .busy(busy3), .done(done3), .pass(pass3), .vec_count(vc3), .err_count(ec3),
    .first_fail_x(fx3), .first_fail_out(fo3)
`ifdef NOT16_CHK_DIFF_MASK_EN
    , .diff_mask(dm3)
`endif
  );

  // ---------------- instance us: LATENCY=0, NUM_VECTORS=65535
  logic rsts, starts, vvs, busys, dones, passs;
  logic [15:0] xs_, os_, vcs, ecs, fxs, fos;
`ifdef NOT16_CHK_DIFF_MASK_EN
  logic [15:0] dms;
`endif
  not16_resp_checker #(.WIDTH(16), .NUM_VECTORS(65535), .LATENCY(0)) us (
    .clk(clk), .rst(rsts), .start(starts), .vec_valid(vvs), .x(xs_), .out(os_),
    .busy(busys), .done(dones), .pass(passs), .vec_count(vcs), .err_count(ecs),
    .first_fail_x(fxs), .first_fail_out(fos)
`ifdef NOT16_CHK_DIFF_MASK_EN
    , .diff_mask(dms)
`endif
  );

  // ---------------- monitors: pop expected run result on each rising done
  logic d0q = 1'b0, d3q = 1'b0, dsq = 1'b0;
  exp_t m0, m3, ms;

  always @(negedge clk) begin
    if (done0 && !d0q) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL u0 done: run completed with no expected result queued");
      end else begin
        m0 = q0.pop_front();
        cmp_run("u0", m0, vc0, ec0, fx0, fo0, busy0, pass0);
`ifdef NOT16_CHK_DIFF_MASK_EN
        chk("u0 diff_mask", 32'(dm0), 32'(m0.mask));
`endif
      end
    end
    d0q = done0;
  end

  always @(negedge clk) begin
    if (done3 && !d3q) begin
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL u3 done: run completed with no expected result queued");
      end else begin
        m3 = q3.pop_front();
        cmp_run("u3", m3, vc3, ec3, fx3, fo3, busy3, pass3);
`ifdef NOT16_CHK_DIFF_MASK_EN
        chk("u3 diff_mask", 32'(dm3), 32'(m3.mask));
`endif
      end
    end
    d3q = done3;
  end

  always @(negedge clk) begin
    if (dones && !dsq) begin
      if (qs.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL us done: run completed with no expected result queued");
      end else begin
        ms = qs.pop_front();
        cmp_run("us", ms, vcs, ecs, fxs, fos, busys, passs);
`ifdef NOT16_CHK_DIFF_MASK_EN
        chk("us diff_mask", 32'(dms), 32'(ms.mask));
`endif
      end
    end
    dsq = dones;
  end

  // ---------------- u0 stimulus
  // mode 0: x=i golden; 1: x=i with out=FFFE at x=0; 2: random x with random bit faults
  task automatic run0(input int n, input int mode, input bit gaps, input bit midstart, input bit push);
    logic [15:0] xs[$], os[$];
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) tick();
      x0 = (mode == 2) ? 16'($urandom) : 16'(i);
      o0 = ~x0;
      if (mode == 1 && x0 == 16'h0000) o0 = 16'hFFFE;
      if (mode == 2 && $urandom_range(0, 7) == 0) o0 = o0 ^ (16'd1 << $urandom_range(0, 15));
      vv0 = 1'b1;
      start0 = midstart && (i == 50);
      xs.push_back(x0);
      os.push_back(o0);
      if (push && i == n - 1) q0.push_back(model(xs, os, cyc + 1));
      tick();
      vv0 = 1'b0;
      start0 = 1'b0;
    end
  endtask

  task automatic wait_done0(input string name);
    int n = 0;
    while (!done0 && n < 50) begin tick(); n++; end
    chk(name, 32'(done0), 32'd1);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic thread0();
    rst0 = 1'b1; start0 = 1'b0; vv0 = 1'b0; x0 = '0; o0 = '0;
    tick(); tick();
    rst0 = 1'b0;
    tick();
    chk("u0 reset busy", 32'(busy0), 0);
    chk("u0 reset done", 32'(done0), 0);
    chk("u0 reset pass", 32'(pass0), 0);
    chk("u0 reset vec_count", 32'(vc0), 0);
    chk("u0 reset err_count", 32'(ec0), 0);
    chk("u0 reset first_fail_x", 32'(fx0), 0);
    chk("u0 reset first_fail_out", 32'(fo0), 0);
    // Faulty vectors while idle must be ignored.
    for (int i = 0; i < 5; i++) begin
      vv0 = 1'b1; x0 = 16'($urandom); o0 = x0;
      tick();
    end
    vv0 = 1'b0;
    chk("u0 idle vec_count", 32'(vc0), 0);
    chk("u0 idle err_count", 32'(ec0), 0);

    pulse_start0();
    chk("u0 busy after start", 32'(busy0), 1);
    run0(100, 0, 1'b0, 1'b0, 1'b1);
    wait_done0("u0 golden done reached");
    // Vectors in DONE are ignored and outputs hold.
    for (int i = 0; i < 3; i++) begin
      vv0 = 1'b1; x0 = 16'($urandom); o0 = x0;
      tick();
    end
    vv0 = 1'b0;
    chk("u0 done hold vec_count", 32'(vc0), 100);
    chk("u0 done hold err_count", 32'(ec0), 0);
    chk("u0 done hold pass", 32'(pass0), 1);

    pulse_start0();
    run0(100, 1, 1'b0, 1'b0, 1'b1);
    wait_done0("u0 single-fault done reached");

    // Restart from DONE clears error state; mid-run start is ignored.
    pulse_start0();
    chk("u0 restart err_count", 32'(ec0), 0);
    chk("u0 restart first_fail_out", 32'(fo0), 0);
    chk("u0 restart pass", 32'(pass0), 0);
    chk("u0 restart busy", 32'(busy0), 1);
    run0(100, 2, 1'b1, 1'b1, 1'b1);
    wait_done0("u0 random midstart done reached");

    // Reset mid-run after 40 vectors.
    pulse_start0();
    run0(40, 2, 1'b0, 1'b0, 1'b0);
    rst0 = 1'b1;
    #1;
    chk("u0 midrun rst busy", 32'(busy0), 0);
    chk("u0 midrun rst vec_count", 32'(vc0), 0);
    chk("u0 midrun rst err_count", 32'(ec0), 0);
    tick();
    rst0 = 1'b0;
    tick();
    pulse_start0();
    run0(100, 0, 1'b0, 1'b0, 1'b1);
    wait_done0("u0 post-reset done reached");

    for (int r = 0; r < 3; r++) begin
      pulse_start0();
      run0(100, 2, 1'b1, 1'b0, 1'b1);
      wait_done0("u0 random done reached");
    end
  endtask

  // ---------------- u3 stimulus
  task automatic thread3();
    logic [15:0] xs[$], os[$];
    exp_t e;
    int n;
    rst3 = 1'b1; start3 = 1'b0; vv3 = 1'b0; x3 = '0; w3 = '0;
    tick(); tick();
    rst3 = 1'b0;
    tick();
    chk("u3 reset busy", 32'(busy3), 0);
    chk("u3 reset vec_count", 32'(vc3), 0);
    for (int r = 0; r < 3; r++) begin
      xs.delete();
      os.delete();
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int i = 0; i < 10; i++) begin
        x3 = 16'($urandom);
        w3 = ~x3;
        if (r > 0 && $urandom_range(0, 2) == 0) w3 = w3 ^ (16'd1 << $urandom_range(0, 15));
        vv3 = 1'b1;
        xs.push_back(x3);
        os.push_back(w3);
        if (i == 9) begin
          e = model(xs, os, cyc + 4);
          q3.push_back(e);
        end
        tick();
        vv3 = 1'b0;
        tick();
      end
      // Faulty extras still in flight at the 10th compare must be dropped.
      for (int i = 0; i < 2; i++) begin
        x3 = 16'($urandom); w3 = x3; vv3 = 1'b1;
        tick();
      end
      vv3 = 1'b0;
      n = 0;
      while (!done3 && n < 30) begin tick(); n++; end
      chk("u3 done reached", 32'(done3), 1);
      repeat (5) tick();
      chk("u3 drained vec_count", 32'(vc3), 10);
      chk("u3 drained err_count", 32'(ec3), 32'(e.err));
    end
  endtask

  // ---------------- us stimulus: constant-wrong DUT (out = x)
  task automatic threads();
    logic [15:0] xs[$], os[$];
    int n;
    rsts = 1'b1; starts = 1'b0; vvs = 1'b0; xs_ = '0; os_ = '0;
    tick(); tick();
    rsts = 1'b0;
    tick();
    starts = 1'b1;
    tick();
    starts = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      xs_ = 16'($urandom);
      os_ = xs_;
      vvs = 1'b1;
      xs.push_back(xs_);
      os.push_back(os_);
      if (i == 65534) qs.push_back(model(xs, os, cyc + 1));
      tick();
    end
    vvs = 1'b0;
    n = 0;
    while (!dones && n < 20) begin tick(); n++; end
    chk("us done reached", 32'(dones), 1);
    chk("us err_count saturated", 32'(ecs), 32'hFFFF);
  endtask

  initial begin
    fork
      thread0();
      thread3();
      threads();
    join
    repeat (3) tick();
    chk("u0 scoreboard drained", q0.size(), 0);
    chk("u3 scoreboard drained", q3.size(), 0);
    chk("us scoreboard drained", qs.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

endmodule
